load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide RAM with range and
// alignment checking; sub-word stores do a read-modify-write of the RAM word.
module load_store_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] MEM_BASE = 32'h00001000,
   parameter logic [WIDTH-1:0] MEM_TOP  = 32'h00001FFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic             resp_err,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             Data_WE,
   output logic [WIDTH-1:0] Data_addr,
   output logic [WIDTH-1:0] Data_WD,
   input  logic [WIDTH-1:0] Data_RD
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             we_r;
   logic [1:0]       size_r;
   logic             uns_r;
   logic [WIDTH-1:0] addr_r;
   logic [WIDTH-1:0] wdata_r;
   logic [WIDTH-1:0] word_r;

   // The last accessed byte is computed one bit wider so a request near the top
   // of the address space cannot wrap around into the valid window.
   function automatic logic access_err(input logic [1:0] size, input logic [WIDTH-1:0] addr);
      logic [WIDTH:0] last;
      logic           bad;
      bad  = 1'b0;
      last = {1'b0, addr};
      case (size)
         2'b00:   last = {1'b0, addr};
         2'b01:   begin bad = addr[0];   last = {1'b0, addr} + (WIDTH+1)'(1); end
         2'b10:   begin bad = |addr[1:0]; last = {1'b0, addr} + (WIDTH+1)'(3); end
         default: bad = 1'b1;
      endcase
      if (addr < MEM_BASE || last > {1'b0, MEM_TOP})
         bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [WIDTH-1:0] load_extract(input logic [WIDTH-1:0] word,
                                                     input logic [1:0] lo,
                                                     input logic [1:0] size,
                                                     input logic uns);
      logic [WIDTH-1:0]   sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [WIDTH-1:0]   r;
      sh = word >> {lo, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (size)
         2'b00:   r = uns ? {{(WIDTH-8){1'b0}}, b}  : {{(WIDTH-8){b[7]}}, b};
         2'b01:   r = uns ? {{(WIDTH-16){1'b0}}, h} : {{(WIDTH-16){h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] merge_store(input logic [WIDTH-1:0] word,
                                                    input logic [WIDTH-1:0] wdata,
                                                    input logic [1:0] lo,
                                                    input logic [1:0] size);
      logic [4:0]       sh;
      logic [WIDTH-1:0] mask;
      logic [WIDTH-1:0] ins;
      if (size == 2'b00) begin
         sh   = {lo, 3'b000};
         mask = WIDTH'(8'hFF) << sh;
         ins  = WIDTH'(wdata[7:0]) << sh;
      end else begin
         sh   = {lo[1], 4'b0000};
         mask = WIDTH'(16'hFFFF) << sh;
         ins  = WIDTH'(wdata[15:0]) << sh;
      end
      return (word & ~mask) | ins;
   endfunction

   assign accept = req_valid && (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Request fields and the RAM snapshot are datapath only; outputs are gated by state.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_r    <= req_we;
         size_r  <= req_size;
         uns_r   <= req_unsigned;
         addr_r  <= req_addr;
         wdata_r <= req_wdata;
      end
      if (state == READ)
         word_r <= Data_RD;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (access_err(req_size, req_addr))
                  state_nxt = ERR;
               else if (req_we && req_size == 2'b10)
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         READ:    state_nxt = we_r ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP) || (state == ERR);
      resp_err   = (state == ERR);
      resp_rdata = '0;
      Data_WE    = (state == WRITE);
      Data_addr  = '0;
      Data_WD    = '0;
      if (state == RESP && !we_r)
         resp_rdata = load_extract(word_r, addr_r[1:0], size_r, uns_r);
      if (state == READ || state == WRITE)
         Data_addr = {addr_r[WIDTH-1:2], 2'b00};
      if (state == WRITE)
         Data_WD = (size_r == 2'b10) ? wdata_r : merge_store(word_r, wdata_r, addr_r[1:0], size_r);
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        Data_WE;
   logic [31:0] Data_addr;
   logic [31:0] Data_WD;
   logic [31:0] Data_RD;

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .Data_WE(Data_WE), .Data_addr(Data_addr),
      .Data_WD(Data_WD), .Data_RD(Data_RD)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:1023];
   int          we_cnt = 0;
   logic [31:0] we_addr = 32'h0;
   logic [31:0] we_data = 32'h0;

   assign Data_RD = mem[Data_addr[11:2]];

   always @(posedge clk) begin
      if (Data_WE) begin
         mem[Data_addr[11:2]] <= Data_WD;
         we_cnt  = we_cnt + 1;
         we_addr = Data_addr;
         we_data = Data_WD;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   int          lat;
   int          we_at;
   int          we_base;
   logic [31:0] rd;
   logic        er;

   task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      we_base = we_cnt; we_at = 0;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      if (Data_WE) we_at = lat;
      while (!resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
         if (Data_WE && we_at == 0) we_at = lat;
      end
      check("resp_seen", {31'b0, resp_valid}, 32'h1);
      rd = resp_rdata;
      er = resp_err;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
      int          exp_lat;
   } vec_t;

   vec_t loads [8];
   vec_t errs [6];
   logic [31:0] bb_addr [3];
   logic [1:0]  bb_size [3];
   logic        bb_uns  [3];
   logic [31:0] bb_exp  [3];
   logic [31:0] bb_got  [3];

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0] = 32'h8899AABB;

      loads[0] = '{0, 2'b00, 0, 32'h1001, 0, 32'hFFFFFFAA, 2};
      loads[1] = '{0, 2'b00, 1, 32'h1001, 0, 32'h000000AA, 2};
      loads[2] = '{0, 2'b00, 0, 32'h1000, 0, 32'hFFFFFFBB, 2};
      loads[3] = '{0, 2'b00, 0, 32'h1003, 0, 32'hFFFFFF88, 2};
      loads[4] = '{0, 2'b01, 0, 32'h1000, 0, 32'hFFFFAABB, 2};
      loads[5] = '{0, 2'b01, 1, 32'h1002, 0, 32'h00008899, 2};
      loads[6] = '{0, 2'b01, 0, 32'h1002, 0, 32'hFFFF8899, 2};
      loads[7] = '{0, 2'b10, 0, 32'h1000, 0, 32'h8899AABB, 2};

      errs[0] = '{0, 2'b10, 0, 32'h1002, 0, 0, 1};
      errs[1] = '{0, 2'b01, 0, 32'h1003, 0, 0, 1};
      errs[2] = '{0, 2'b00, 0, 32'h0FFF, 0, 0, 1};
      errs[3] = '{0, 2'b10, 0, 32'h1FFE, 0, 0, 1};
      errs[4] = '{0, 2'b11, 0, 32'h1000, 0, 0, 1};
      errs[5] = '{1, 2'b00, 0, 32'h2000, 32'h11, 0, 1};

      // Reset state, sampled while rst is held
      #2;
      check("rst_ready", {31'b0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      check("rst_resp_err", {31'b0, resp_err}, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_we", {31'b0, Data_WE}, 32'h0);
      check("rst_addr", Data_addr, 32'h0);
      check("rst_wd", Data_WD, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (loads[i]) begin
         access(loads[i].we, loads[i].sz, loads[i].uns, loads[i].a, loads[i].wd);
         check($sformatf("load%0d_data", i), rd, loads[i].exp);
         check($sformatf("load%0d_lat", i), 32'(lat), 32'(loads[i].exp_lat));
         check($sformatf("load%0d_err", i), {31'b0, er}, 32'h0);
      end

      // Half store: read-modify-write
      access(1, 2'b01, 0, 32'h1002, 32'h00001234);
      check("sh_lat", 32'(lat), 32'd3);
      check("sh_we_cnt", 32'(we_cnt - we_base), 32'd1);
      check("sh_we_addr", we_addr, 32'h1000);
      check("sh_we_data", we_data, 32'h1234AABB);
      check("sh_rdata", rd, 32'h0);
      check("sh_err", {31'b0, er}, 32'h0);

      access(1, 2'b00, 0, 32'h1001, 32'hFFFFFF55);
      check("sb_lat", 32'(lat), 32'd3);
      check("sb_we_data", we_data, 32'h123455BB);
      access(0, 2'b10, 0, 32'h1000, 0);
      check("sb_readback", rd, 32'h123455BB);

      // Word store at the top word: no READ phase
      access(1, 2'b10, 0, 32'h1FFC, 32'hDEADBEEF);
      check("sw_we_at", 32'(we_at), 32'd1);
      check("sw_lat", 32'(lat), 32'd2);
      check("sw_we_cnt", 32'(we_cnt - we_base), 32'd1);
      check("sw_we_addr", we_addr, 32'h1FFC);
      access(0, 2'b10, 0, 32'h1FFC, 0);
      check("sw_readback", rd, 32'hDEADBEEF);
      access(0, 2'b00, 0, 32'h1FFF, 0);
      check("top_byte", rd, 32'hFFFFFFDE);
      access(0, 2'b01, 1, 32'h1FFE, 0);
      check("top_half", rd, 32'h0000DEAD);

      foreach (errs[i]) begin
         access(errs[i].we, errs[i].sz, errs[i].uns, errs[i].a, errs[i].wd);
         check($sformatf("err%0d_flag", i), {31'b0, er}, 32'h1);
         check($sformatf("err%0d_lat", i), 32'(lat), 32'd1);
         check($sformatf("err%0d_rdata", i), rd, 32'h0);
         check($sformatf("err%0d_we", i), 32'(we_cnt - we_base), 32'd0);
      end

      // Reset while a byte store sits in READ
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h1000; req_wdata = 32'h77;
      we_base = we_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      check("rr_read_addr", Data_addr, 32'h1000);
      #1 rst = 1'b1;
      #1;
      check("rr_ready", {31'b0, req_ready}, 32'h1);
      check("rr_addr", Data_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
         end
         check("rr_no_resp", 32'(seen), 32'd0);
      end
      check("rr_no_we", 32'(we_cnt - we_base), 32'd0);
      access(0, 2'b10, 0, 32'h1000, 0);
      check("rr_readback", rd, 32'h123455BB);

      // Reset while a word store sits in WRITE
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
      req_addr = 32'h1000; req_wdata = 32'hCAFEF00D;
      we_base = we_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      check("rw_we_high", {31'b0, Data_WE}, 32'h1);
      #1 rst = 1'b1;
      #1;
      check("rw_we_low", {31'b0, Data_WE}, 32'h0);
      check("rw_wd", Data_WD, 32'h0);
      check("rw_resp", {31'b0, resp_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check("rw_no_we", 32'(we_cnt - we_base), 32'd0);
      access(0, 2'b10, 0, 32'h1000, 0);
      check("rw_readback", rd, 32'h123455BB);

      // Back-to-back loads with req_valid held high
      bb_addr = '{32'h1000, 32'h1FFC, 32'h1001};
      bb_size = '{2'b10, 2'b10, 2'b00};
      bb_uns  = '{1'b0, 1'b0, 1'b1};
      bb_exp  = '{32'h123455BB, 32'hDEADBEEF, 32'h00000055};
      bb_got  = '{32'h0, 32'h0, 32'h0};
      begin
         int  idx = 0, acc = 0, nresp = 0, busy_ready = 0;
         logic adv;
         req_valid = 1'b1; req_we = 1'b0; req_size = bb_size[0];
         req_unsigned = bb_uns[0]; req_addr = bb_addr[0];
         for (int k = 0; k < 30; k++) begin
            adv = req_valid && req_ready;
            if (adv) acc++;
            @(negedge clk);
            if (adv) begin
               idx++;
               if (idx < 3) begin
                  req_size = bb_size[idx]; req_unsigned = bb_uns[idx]; req_addr = bb_addr[idx];
               end else
                  req_valid = 1'b0;
            end
            if (resp_valid) begin
               if (nresp < 3) bb_got[nresp] = resp_rdata;
               nresp++;
               if (req_ready) busy_ready++;
            end
         end
         req_valid = 1'b0;
         check("bb_accepts", 32'(acc), 32'd3);
         check("bb_resps", 32'(nresp), 32'd3);
         check("bb_ready_busy", 32'(busy_ready), 32'd0);
         for (int i = 0; i < 3; i++)
            check($sformatf("bb_data%0d", i), bb_got[i], bb_exp[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
